rns_floor_q_to_bba: RTL and testbench

- Multi-cycle BEHZ scale-and-floor stage. Takes the tensored ciphertext polynomial in the q∪BBa basis and computes approximately floor(t·x/q) in the BBa basis.
- Its output feeds fastBConvEx_BBa_to_q directly, in the same BBa slot ordering: B moduli first, then Ba.
- The conversion step uses the existing fastBConv module (q→BBa). The block adds input capture, pre-scaling, correction and a ready/valid handshake.

---
 rtl/rns_floor_q_to_bba_pkg.sv | 66 ++++++
 rtl/fastBConv.sv | 65 ++++++
 rtl/rns_floor_q_to_bba.sv | 135 +++++++++++++
 tb/tb_rns_floor_q_to_bba.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rns_floor_q_to_bba_pkg.sv
// +--------------------------------------------------------------------------+
// | rns_floor_q_to_bba_pkg : bases, BEHZ constants and modular helpers        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rns_floor_q_to_bba_pkg;

  localparam int N_SLOTS        = 1;
  localparam int RNS_PRIME_BITS = 5;
  localparam int q_BASIS_LEN    = 2;
  localparam int B_BASIS_LEN    = 2;
  localparam int Ba_BASIS_LEN   = 1;
  localparam int BBa_BASIS_LEN  = B_BASIS_LEN + Ba_BASIS_LEN;
  localparam int QBBA_LEN       = q_BASIS_LEN + BBa_BASIS_LEN;

  typedef logic [RNS_PRIME_BITS-1:0]       rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS-1:0]     wide_rns_residue_t;
  typedef logic signed [RNS_PRIME_BITS:0]  rns_diff_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_CONV  = 2'd2,
    ST_CORR  = 2'd3
  } state_t;

  localparam rns_residue_t PLAINTEXT_T = 5'd3;

  // Index 0 is the rightmost element of each concatenation.
  localparam rns_residue_t [q_BASIS_LEN-1:0]   q_BASIS      = {5'd11, 5'd7};
  localparam rns_residue_t [BBa_BASIS_LEN-1:0] BBa_BASIS    = {5'd19, 5'd17, 5'd13};
  localparam rns_residue_t [q_BASIS_LEN-1:0]   z_MOD_q      = {5'd8, 5'd2};
  localparam rns_residue_t [BBa_BASIS_LEN-1:0] qinv_MOD_BBa = {5'd1, 5'd2, 5'd12};
  localparam rns_residue_t [BBa_BASIS_LEN-1:0][q_BASIS_LEN-1:0] y_q_TO_BBa =
    {5'd7, 5'd11, 5'd7, 5'd11, 5'd7, 5'd11};

  function automatic rns_residue_t mulmod(input rns_residue_t a,
                                          input rns_residue_t b,
                                          input rns_residue_t m);
    wide_rns_residue_t prod;
    prod = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
    return rns_residue_t'(prod % wide_rns_residue_t'(m));
  endfunction

  function automatic rns_residue_t addmod(input rns_residue_t a,
                                          input rns_residue_t b,
                                          input rns_residue_t m);
    logic [RNS_PRIME_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return rns_residue_t'(s);
  endfunction

  function automatic rns_residue_t submod(input rns_residue_t a,
                                          input rns_residue_t b,
                                          input rns_residue_t m);
    rns_diff_t d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = d + $signed({1'b0, m});
    return rns_residue_t'(d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fastBConv.sv
// +--------------------------------------------------------------------------+
// | fastBConv : fast base conversion q -> BBa with a LATENCY-deep pipeline    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fastBConv
  import rns_floor_q_to_bba_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  rns_residue_t in_poly  [N_SLOTS][q_BASIS_LEN],
  output logic         out_valid,
  output rns_residue_t out_poly [N_SLOTS][BBa_BASIS_LEN]
);

  rns_residue_t     scaled_w [N_SLOTS][q_BASIS_LEN];
  rns_residue_t     conv_w   [N_SLOTS][BBa_BASIS_LEN];
  rns_residue_t     pipe_d   [LATENCY][N_SLOTS][BBa_BASIS_LEN];
  rns_residue_t     pipe_q   [LATENCY][N_SLOTS][BBa_BASIS_LEN];
  logic [LATENCY-1:0] vld_d, vld_q;

  // conv[j] = sum_i ([x_i * z_i]_qi * (q/q_i)) mod m_j, no q-overflow correction
  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      for (int i = 0; i < q_BASIS_LEN; i++)
        scaled_w[k][i] = mulmod(in_poly[k][i], z_MOD_q[i], q_BASIS[i]);
      for (int j = 0; j < BBa_BASIS_LEN; j++) begin
        conv_w[k][j] = '0;
        for (int i = 0; i < q_BASIS_LEN; i++)
          conv_w[k][j] = addmod(conv_w[k][j],
                                mulmod(scaled_w[k][i], y_q_TO_BBa[j][i], BBa_BASIS[j]),
                                BBa_BASIS[j]);
      end
    end
  end

  always_comb begin
    pipe_d[0] = conv_w;
    vld_d[0]  = in_valid;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
      vld_d[s]  = vld_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      pipe_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_poly  = pipe_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/rns_floor_q_to_bba.sv
// +--------------------------------------------------------------------------+
// | rns_floor_q_to_bba : BEHZ scale-and-floor, q u BBa -> BBa (~floor(tx/q))  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rns_floor_q_to_bba
  import rns_floor_q_to_bba_pkg::*;
#(
  parameter int CONV_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  rns_residue_t input_RNSpoly  [N_SLOTS][QBBA_LEN],
  output logic         out_valid,
  output rns_residue_t output_RNSpoly [N_SLOTS][BBa_BASIS_LEN]
);

  localparam int CNT_W = $clog2(CONV_LAT + 1);

  state_t             state_d, state_q;
  rns_residue_t       x_d        [N_SLOTS][QBBA_LEN];
  rns_residue_t       x_q        [N_SLOTS][QBBA_LEN];
  rns_residue_t       scaled_d   [N_SLOTS][q_BASIS_LEN];
  rns_residue_t       scaled_q   [N_SLOTS][q_BASIS_LEN];
  rns_residue_t       conv_res_d [N_SLOTS][BBa_BASIS_LEN];
  rns_residue_t       conv_res_q [N_SLOTS][BBa_BASIS_LEN];
  rns_residue_t       out_d      [N_SLOTS][BBa_BASIS_LEN];
  rns_residue_t       out_q      [N_SLOTS][BBa_BASIS_LEN];
  logic               conv_start_d, conv_start_q;
  logic               out_valid_d, out_valid_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  logic               conv_out_valid;
  rns_residue_t       conv_out [N_SLOTS][BBa_BASIS_LEN];

  fastBConv #(
    .LATENCY (CONV_LAT)
  ) u_fastbconv (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (conv_start_q),
    .in_poly   (scaled_q),
    .out_valid (conv_out_valid),
    .out_poly  (conv_out)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    scaled_d     = scaled_q;
    conv_res_d   = conv_res_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    conv_start_d = 1'b0;
    out_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = input_RNSpoly;
          state_d = ST_SCALE;
        end
      end

      ST_SCALE: begin
        for (int k = 0; k < N_SLOTS; k++)
          for (int i = 0; i < q_BASIS_LEN; i++)
            scaled_d[k][i] = mulmod(x_q[k][i], PLAINTEXT_T, q_BASIS[i]);
        conv_start_d = 1'b1;
        cnt_d        = '0;
        state_d      = ST_CONV;
      end

      ST_CONV: begin
        if (cnt_q != CNT_W'(CONV_LAT)) cnt_d = cnt_q + 1'b1;
        if (conv_out_valid) begin
          conv_res_d = conv_out;
          state_d    = ST_CORR;
        end
      end

      ST_CORR: begin
        // out = ((t*x mod m_j) - conv) * q^-1 mod m_j
        for (int k = 0; k < N_SLOTS; k++)
          for (int j = 0; j < BBa_BASIS_LEN; j++)
            out_d[k][j] = mulmod(
                submod(mulmod(x_q[k][q_BASIS_LEN+j], PLAINTEXT_T, BBa_BASIS[j]),
                       conv_res_q[k][j], BBa_BASIS[j]),
                qinv_MOD_BBa[j], BBa_BASIS[j]);
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '{default: '0};
      scaled_q     <= '{default: '0};
      conv_res_q   <= '{default: '0};
      out_q        <= '{default: '0};
      cnt_q        <= '0;
      conv_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      scaled_q     <= scaled_d;
      conv_res_q   <= conv_res_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      conv_start_q <= conv_start_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // The converter must answer exactly CONV_LAT cycles after its start pulse.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_CONV)
      assert (conv_out_valid == (cnt_q == CNT_W'(CONV_LAT)));
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign out_valid      = out_valid_q;
  assign output_RNSpoly = out_q;

endmodule

`default_nettype wire

// File: tb/tb_rns_floor_q_to_bba.sv
// +--------------------------------------------------------------------------+
// | tb_rns_floor_q_to_bba : directed vector table plus handshake corner cases  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rns_floor_q_to_bba;
  import rns_floor_q_to_bba_pkg::*;

  localparam int CONV_LAT = 2;

  typedef struct {
    int x;
    int q0, q1, b0, b1, ba;
    int o0, o1, o2;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  rns_residue_t input_RNSpoly  [N_SLOTS][QBBA_LEN];
  rns_residue_t output_RNSpoly [N_SLOTS][BBa_BASIS_LEN];

  int n_cmp = 0;
  int n_err = 0;
  int mods [5] = '{7, 11, 13, 17, 19};

  always #5 clk = ~clk;

  rns_floor_q_to_bba #(
    .CONV_LAT (CONV_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input_RNSpoly  (input_RNSpoly),
    .out_valid      (out_valid),
    .output_RNSpoly (output_RNSpoly)
  );

  task automatic check1(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input int e0, input int e1, input int e2);
    int g0, g1, g2;
    g0 = int'(output_RNSpoly[0][0]);
    g1 = int'(output_RNSpoly[0][1]);
    g2 = int'(output_RNSpoly[0][2]);
    n_cmp++;
    if (g0 != e0 || g1 != e1 || g2 != e2) begin
      n_err++;
      $display("FAIL %s: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
               name, g0, g1, g2, e0, e1, e2);
    end
  endtask

  task automatic set_res(input int q0, input int q1, input int b0, input int b1, input int ba);
    input_RNSpoly[0][0] = rns_residue_t'(q0);
    input_RNSpoly[0][1] = rns_residue_t'(q1);
    input_RNSpoly[0][2] = rns_residue_t'(b0);
    input_RNSpoly[0][3] = rns_residue_t'(b1);
    input_RNSpoly[0][4] = rns_residue_t'(ba);
  endtask

  task automatic set_x(input int x);
    set_res(x % mods[0], x % mods[1], x % mods[2], x % mods[3], x % mods[4]);
  endtask

  task automatic accept();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from now until out_valid is seen; bounded.
  task automatic wait_out(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t vecs [6];

  initial begin
    int  edges;
    bit  ok;
    bit  held_ok;
    bit  quiet_ok;

    vecs[0] = '{x: 0,  q0: 0, q1: 0,  b0: 0,  b1: 0,  ba: 0,  o0: 0,  o1: 0,  o2: 0};
    vecs[1] = '{x: 76, q0: 6, q1: 10, b0: 11, b1: 8,  ba: 0,  o0: 2,  o1: 2,  o2: 2};
    vecs[2] = '{x: 1,  q0: 1, q1: 1,  b0: 1,  b1: 1,  ba: 1,  o0: 12, o1: 16, o2: 18};
    vecs[3] = '{x: 50, q0: 1, q1: 6,  b0: 11, b1: 16, ba: 12, o0: 1,  o1: 1,  o2: 1};
    vecs[4] = '{x: 26, q0: 5, q1: 4,  b0: 0,  b1: 9,  ba: 7,  o0: 0,  o1: 0,  o2: 0};
    vecs[5] = '{x: 75, q0: 5, q1: 9,  b0: 10, b1: 7,  ba: 18, o0: 2,  o1: 2,  o2: 2};

    reset    = 1'b1;
    in_valid = 1'b0;
    set_x(0);
    repeat (3) @(posedge clk);
    #1;
    check1("rst_out_valid", int'(out_valid), 0);
    check1("rst_in_ready", int'(in_ready), 1);
    check_out("rst_output", 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      set_res(vecs[i].q0, vecs[i].q1, vecs[i].b0, vecs[i].b1, vecs[i].ba);
      check1($sformatf("x%0d_ready", vecs[i].x), int'(in_ready), 1);
      accept();
      wait_out(edges, ok);
      check1($sformatf("x%0d_timeout", vecs[i].x), int'(ok), 1);
      check1($sformatf("x%0d_latency", vecs[i].x), edges, CONV_LAT + 3);
      check_out($sformatf("x%0d_out", vecs[i].x), vecs[i].o0, vecs[i].o1, vecs[i].o2);
      check1($sformatf("x%0d_ready_at_valid", vecs[i].x), int'(in_ready), 1);
      @(posedge clk); #1;
      check1($sformatf("x%0d_pulse", vecs[i].x), int'(out_valid), 0);
      check_out($sformatf("x%0d_hold", vecs[i].x), vecs[i].o0, vecs[i].o1, vecs[i].o2);
    end

    // Back-to-back with in_valid held high through the busy cycles
    set_x(76);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_x(50);
    wait_out(edges, ok);
    check1("b2b_first_timeout", int'(ok), 1);
    check1("b2b_first_latency", edges, CONV_LAT + 3);
    check_out("b2b_first_out", 2, 2, 2);
    set_x(1);
    @(posedge clk); #1;
    set_x(50);
    edges    = 1;
    held_ok  = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (output_RNSpoly[0][0] != 5'd2 || output_RNSpoly[0][1] != 5'd2 ||
          output_RNSpoly[0][2] != 5'd2) held_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check1("b2b_second_timeout", int'(ok), 1);
    check1("b2b_held_between", int'(held_ok), 1);
    check1("b2b_gap", edges, CONV_LAT + 4);
    check_out("b2b_second_out", 12, 16, 18);
    quiet_ok = 1'b1;
    repeat (2 * CONV_LAT + 8) begin
      @(posedge clk); #1;
      if (out_valid) quiet_ok = 1'b0;
    end
    check1("b2b_no_extra_pulse", int'(quiet_ok), 1);

    // Reset while the converter is busy
    set_x(76);
    accept();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check1("abort_in_ready", int'(in_ready), 1);
    check1("abort_out_valid", int'(out_valid), 0);
    check_out("abort_output", 0, 0, 0);
    quiet_ok = 1'b1;
    repeat (2 * CONV_LAT + 8) begin
      @(posedge clk); #1;
      if (out_valid) quiet_ok = 1'b0;
    end
    check1("abort_no_pulse", int'(quiet_ok), 1);
    set_x(76);
    accept();
    wait_out(edges, ok);
    check1("after_abort_timeout", int'(ok), 1);
    check_out("after_abort_out", 2, 2, 2);

    // Random polys against floor(3x/77) with the allowed -1 error
    for (int n = 0; n < 1000; n++) begin
      int x, fl, g0, g1, g2;
      bit match;
      x = int'($urandom_range(76, 0));
      fl = (3 * x) / 77;
      @(posedge clk); #1;
      set_x(x);
      accept();
      wait_out(edges, ok);
      g0 = int'(output_RNSpoly[0][0]);
      g1 = int'(output_RNSpoly[0][1]);
      g2 = int'(output_RNSpoly[0][2]);
      match = 1'b0;
      for (int e = 0; e <= 1; e++) begin
        int r;
        r = fl - e;
        if (g0 == ((r % 13) + 13) % 13 && g1 == ((r % 17) + 17) % 17 &&
            g2 == ((r % 19) + 19) % 19) match = 1'b1;
      end
      n_cmp++;
      if (!ok || !match) begin
        n_err++;
        $display("FAIL rand_x%0d: got (%0d,%0d,%0d) valid=%0d, expected floor %0d or %0d",
                 x, g0, g1, g2, ok, fl, fl - 1);
      end
      @(posedge clk); #1;
      check1("rand_single_pulse", int'(out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
